// File: rtl/manchester_frame_tx.sv
// Manchester frame transmitter: preamble, sync word, payload and optional even
// parity, each bit sent as two half-bits of HALF_DIV cycles, then an idle gap.
// Latency: line_out shows the first half-bit on the edge after the accepting
// edge. Backpressure: s_ready is low from acceptance until the gap ends.
//
// Ports:
//   clk108     in   clock, rising edge
//   aresetn    in   synchronous active-low reset
//   s_data     in   payload (DATA_W bits), sampled on the accepting edge
//   s_valid    in   payload valid
//   s_ready    out  high while idle and ready to take a frame
//   line_out   out  registered Manchester line
//   busy       out  frame or gap in progress
//   frame_done out  one-cycle pulse during the last cycle of the last frame bit
module manchester_frame_tx #(
  parameter int          DATA_W     = 32,
  parameter int          HALF_DIV   = 1,
  parameter int          PRE_BITS   = 8,
  parameter int          SYNC_W     = 8,
  parameter logic [15:0] SYNC       = 16'h00D5,
  parameter int          MSB_FIRST  = 0,
  parameter int          PARITY_EN  = 1,
  parameter int          GAP_BITS   = 2,
  parameter int          POLARITY   = 0,
  parameter int          IDLE_LEVEL = 0
) (
  input  logic              clk108,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              line_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAXB0 = (PRE_BITS > SYNC_W) ? PRE_BITS : SYNC_W;
  localparam int MAXB1 = (MAXB0 > DATA_W) ? MAXB0 : DATA_W;
  localparam int MAXB  = (MAXB1 > GAP_BITS) ? MAXB1 : GAP_BITS;
  localparam int BW    = $clog2(MAXB + 1);
  localparam int HW    = $clog2(HALF_DIV + 1);

  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_DIV - 1);
  localparam logic [BW-1:0] PRE_LAST  = BW'((PRE_BITS > 0) ? PRE_BITS - 1 : 0);
  localparam logic [BW-1:0] SYNC_LAST = BW'(SYNC_W - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] GAP_LAST  = BW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  localparam logic [SYNC_W-1:0] SYNC_V = SYNC[SYNC_W-1:0];
  localparam logic IDLE_L = (IDLE_LEVEL != 0);
  localparam logic MSB    = (MSB_FIRST != 0);
  localparam logic POL    = (POLARITY != 0);
  localparam logic PAR_ON = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SYNC,
    ST_DATA,
    ST_PAR,
    ST_GAP
  } state_t;

  // State after the last frame bit: the gap, or straight back to idle.
  localparam state_t ST_AFTER = (GAP_BITS > 0) ? ST_GAP : ST_IDLE;

  state_t              state_q, state_d;
  logic [HW-1:0]       hcnt_q, hcnt_d;   // cycle within the current half-bit
  logic                phase_q, phase_d; // 0 = first half, 1 = second half
  logic [BW-1:0]       bcnt_q, bcnt_d;   // bit index within the current field
  logic [DATA_W-1:0]   dsh_q, dsh_d;
  logic [SYNC_W-1:0]   ssh_q, ssh_d;
  logic                par_q, par_d;
  logic                s_ready_q, s_ready_d;
  logic                line_q, line_d;
  logic                done_q, done_d;

  logic                half_end;
  logic                bit_end;
  logic                cur_bit;
  logic                tx_on;

  assign half_end = (hcnt_q == HALF_LAST);
  assign bit_end  = phase_q & half_end;

  always_ff @(posedge clk108) begin
    if (!aresetn) begin
      state_q   <= ST_IDLE;
      hcnt_q    <= '0;
      phase_q   <= 1'b0;
      bcnt_q    <= '0;
      dsh_q     <= '0;
      ssh_q     <= '0;
      par_q     <= 1'b0;
      s_ready_q <= 1'b0;
      line_q    <= IDLE_L;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      phase_q   <= phase_d;
      bcnt_q    <= bcnt_d;
      dsh_q     <= dsh_d;
      ssh_q     <= ssh_d;
      par_q     <= par_d;
      s_ready_q <= s_ready_d;
      line_q    <= line_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    dsh_d   = dsh_q;
    ssh_d   = ssh_q;
    par_d   = par_q;
    done_d  = 1'b0;
    cur_bit = 1'b0;
    tx_on   = 1'b0;

    // Half-bit timing runs in every active state, gap included; the bit_end
    // wrap leaves hcnt/phase at zero for whatever comes next.
    if (state_q != ST_IDLE) begin
      if (half_end) begin
        hcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (s_valid && s_ready_q) begin
          state_d = (PRE_BITS > 0) ? ST_PRE : ST_SYNC;
          hcnt_d  = '0;
          phase_d = 1'b0;
          bcnt_d  = '0;
          dsh_d   = s_data;
          ssh_d   = SYNC_V;
          par_d   = ^s_data;
        end
      end
      ST_PRE: begin
        tx_on   = 1'b1;
        cur_bit = ~bcnt_q[0];  // 1,0,1,... starting with 1
        if (bit_end) begin
          if (bcnt_q == PRE_LAST) begin
            state_d = ST_SYNC;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ST_SYNC: begin
        tx_on   = 1'b1;
        cur_bit = MSB ? ssh_q[SYNC_W-1] : ssh_q[0];
        if (bit_end) begin
          ssh_d = MSB ? (ssh_q << 1) : (ssh_q >> 1);
          if (bcnt_q == SYNC_LAST) begin
            state_d = ST_DATA;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        tx_on   = 1'b1;
        cur_bit = MSB ? dsh_q[DATA_W-1] : dsh_q[0];
        if (bit_end) begin
          dsh_d = MSB ? (dsh_q << 1) : (dsh_q >> 1);
          if (bcnt_q == DATA_LAST) begin
            bcnt_d = '0;
            if (PAR_ON) begin
              state_d = ST_PAR;
            end else begin
              state_d = ST_AFTER;
              done_d  = 1'b1;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        tx_on   = 1'b1;
        cur_bit = par_q;
        if (bit_end) begin
          state_d = ST_AFTER;
          bcnt_d  = '0;
          done_d  = 1'b1;
        end
      end
      ST_GAP: begin
        if (bit_end) begin
          if (bcnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            bcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line is registered one cycle behind the state that computes it, which
    // gives the one-cycle accept-to-line latency and aligns frame_done.
    if (tx_on) begin
      line_d = (POL ? cur_bit : ~cur_bit) ^ phase_q;
    end else begin
      line_d = IDLE_L;
    end

    s_ready_d = (state_d == ST_IDLE);
  end

  assign s_ready    = s_ready_q;
  assign busy       = (state_q != ST_IDLE);
  assign line_out   = line_q;
  assign frame_done = done_q;

endmodule
